// File: rtl/move_exec_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : move_exec_arbiter_if
// Description : Handshake and data bundle between move_exec_arbiter and its
//               environment: board load, two move request ports, the shared
//               move_executor request/result channel and status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface move_exec_arbiter_if #(
    parameter int BOARD_W = 64,
    parameter int MOVE_W  = 16
);
    // Board load channel
    logic [BOARD_W-1:0] load_board_in;
    logic               load_valid_in;
    logic               load_ready_out;

    // Move port 0 (UCI command parser)
    logic [MOVE_W-1:0]  req0_move_in;
    logic               req0_valid_in;
    logic               req0_ready_out;
    logic               req0_done_out;

    // Move port 1 (search engine bestmove commit)
    logic [MOVE_W-1:0]  req1_move_in;
    logic               req1_valid_in;
    logic               req1_ready_out;
    logic               req1_done_out;

    // Shared executor request / result
    logic [BOARD_W-1:0] exec_board_out;
    logic [MOVE_W-1:0]  exec_move_out;
    logic               exec_valid_out;
    logic [BOARD_W-1:0] exec_board_in;
    logic               exec_valid_in;

    // Board and status
    logic [BOARD_W-1:0] board_out;
    logic               board_valid_out;
    logic               busy_out;
    logic               timeout_out;

    // Arbiter side
    modport slave (
        input  load_board_in, load_valid_in,
        output load_ready_out,
        input  req0_move_in, req0_valid_in,
        output req0_ready_out, req0_done_out,
        input  req1_move_in, req1_valid_in,
        output req1_ready_out, req1_done_out,
        output exec_board_out, exec_move_out, exec_valid_out,
        input  exec_board_in, exec_valid_in,
        output board_out, board_valid_out, busy_out, timeout_out
    );

    // Environment side
    modport master (
        output load_board_in, load_valid_in,
        input  load_ready_out,
        output req0_move_in, req0_valid_in,
        input  req0_ready_out, req0_done_out,
        output req1_move_in, req1_valid_in,
        input  req1_ready_out, req1_done_out,
        input  exec_board_out, exec_move_out, exec_valid_out,
        output exec_board_in, exec_valid_in,
        input  board_out, board_valid_out, busy_out, timeout_out
    );
endinterface
`default_nettype wire

// File: rtl/move_exec_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : move_exec_arbiter
// Description : Owns the current board, accepts board loads and arbitrates
//               two move request ports round-robin onto one shared
//               move_executor, with a result timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module move_exec_arbiter #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int BOARD_W        = 64,
    parameter int MOVE_W         = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    move_exec_arbiter_if.slave bus
);

    // Counter only has to reach TIMEOUT_CYCLES-1
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    logic [BOARD_W-1:0] r_board;
    logic [MOVE_W-1:0]  r_move;
    logic               r_port;        // port of the operation in flight
    logic               r_last_grant;  // port granted most recently
    logic [CNT_W-1:0]   r_cnt;
    logic               r_exec_valid;
    logic               r_done0;
    logic               r_done1;
    logic               r_board_valid;
    logic               r_busy;
    logic               r_timeout;

    logic               w_idle;
    logic               w_load_fire;
    logic               w_any_req;
    logic               w_grant_port;
    logic               w_move_fire;
    logic [MOVE_W-1:0]  w_grant_move;

    // Round-robin grant; a pending load blocks both move ports
    always_comb begin
        w_idle      = (r_state == S_IDLE);
        w_load_fire = w_idle && bus.load_valid_in;
        w_any_req   = bus.req0_valid_in || bus.req1_valid_in;
        if (bus.req0_valid_in && bus.req1_valid_in) begin
            w_grant_port = ~r_last_grant;
        end else begin
            w_grant_port = bus.req1_valid_in;
        end
        w_grant_move = w_grant_port ? bus.req1_move_in : bus.req0_move_in;
        w_move_fire  = w_idle && !bus.load_valid_in && w_any_req;
    end

    assign bus.load_ready_out  = w_idle;
    assign bus.req0_ready_out  = w_move_fire && !w_grant_port;
    assign bus.req1_ready_out  = w_move_fire &&  w_grant_port;

    assign bus.board_out       = r_board;
    assign bus.exec_board_out  = r_board;
    assign bus.exec_move_out   = r_move;
    assign bus.exec_valid_out  = r_exec_valid;
    assign bus.req0_done_out   = r_done0;
    assign bus.req1_done_out   = r_done1;
    assign bus.board_valid_out = r_board_valid;
    assign bus.busy_out        = r_busy;
    assign bus.timeout_out     = r_timeout;

    // Operation FSM with registered pulse and status outputs
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state       <= S_IDLE;
            r_board       <= '0;
            r_move        <= '0;
            r_port        <= 1'b0;
            r_last_grant  <= 1'b1;     // port 0 wins the first tie
            r_cnt         <= '0;
            r_exec_valid  <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_board_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            // Pulses default low; each is raised for exactly one cycle
            r_exec_valid  <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            r_board_valid <= 1'b0;
            r_timeout     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load_fire) begin
                        r_board       <= bus.load_board_in;
                        r_board_valid <= 1'b1;
                    end else if (w_move_fire) begin
                        r_move       <= w_grant_move;
                        r_port       <= w_grant_port;
                        r_last_grant <= w_grant_port;
                        r_exec_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A result on the last wait cycle still beats the timeout
                    if (bus.exec_valid_in) begin
                        r_board       <= bus.exec_board_in;
                        r_board_valid <= 1'b1;
                        r_done0       <= ~r_port;
                        r_done1       <=  r_port;
                        r_state       <= S_DONE;
                    end else if (r_cnt == C_CNT_LAST) begin
                        r_timeout <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/move_exec_arbiter.md
MOVE_EXEC_ARBITER -- requirements
Module: move_exec_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max cycles to wait for an executor result before abort.
REQ-002 clk_in  input  1  system clock; all logic on rising edge.
REQ-003 rst_in  input  1  synchronous, active-high reset.
REQ-004 load_board_in  input  board_t  board to install, e.g. startpos.
REQ-005 load_valid_in / load_ready_out  input / output  1 / 1  load handshake.
REQ-006 req0_move_in  input  move_t  move from the UCI command parser.
REQ-007 req0_valid_in / req0_ready_out / req0_done_out  input / output / output  1 each  port 0 handshake plus completion pulse.
REQ-008 req1_move_in, req1_valid_in, req1_ready_out, req1_done_out  same as port 0; source is the search engine's bestmove commit.
REQ-009 exec_board_out / exec_move_out / exec_valid_out  output  board_t / move_t / 1  request to the shared move_executor.
REQ-010 exec_board_in / exec_valid_in  input  board_t / 1  executor result and valid strobe.
REQ-011 board_out / board_valid_out  output  board_t / 1  current board; valid pulses on every board change.
REQ-012 busy_out / timeout_out  output  1 / 1  operation in flight; timeout pulse.

Function
REQ-013 The block SHALL own a board register (board_reg), continuously driven on board_out and exec_board_out.
REQ-014 States SHALL be IDLE, ISSUE, WAIT, DONE; busy_out SHALL be 1 in every state except IDLE.
REQ-015 load_ready_out SHALL be 1 only in IDLE. A load SHALL take priority over both move ports in the same cycle.
REQ-016 A load SHALL be accepted on load_valid_in && load_ready_out. On the next cycle, board_reg = load_board_in, board_valid_out = 1 for one cycle, state stays IDLE.
REQ-017 reqN_ready_out SHALL be combinational and asserted only in IDLE, with load_valid_in = 0, and only to the granted port.
REQ-018 Arbitration SHALL be round-robin:
  - only one port valid: that port is granted;
  - both valid: grant the port not recorded in last_grant.
REQ-019 On move acceptance, the block SHALL:
  - latch the move and the granted port id;
  - update last_grant to that port;
  - go to ISSUE.
REQ-020 In ISSUE, exec_valid_out = 1 with exec_move_out = latched move for exactly one cycle, then go to WAIT. exec_valid_out SHALL be 0 in all other states.
REQ-021 In WAIT, a cycle counter SHALL count from 0. On exec_valid_in = 1:
  - board_reg = exec_board_in;
  - go to DONE.
REQ-022 exec_valid_in received outside WAIT SHALL be ignored; board_reg stays unchanged.
REQ-023 In DONE, for one cycle:
  - reqN_done_out = 1 for the latched port only;
  - board_valid_out = 1;
  - next state IDLE.
REQ-024 Minimum latency SHALL be 4 cycles, acceptance edge to done pulse, when the executor responds one cycle after exec_valid_out.
REQ-025 If the counter reaches TIMEOUT_CYCLES-1 in WAIT without exec_valid_in, the block SHALL:
  - pulse timeout_out for one cycle;
  - leave board_reg unchanged;
  - assert no done pulse;
  - return to IDLE.
REQ-026 If exec_valid_in and the timeout condition occur in the same cycle, the result SHALL win and no timeout SHALL be signalled.
REQ-027 At most one operation SHALL be in flight; a requester holding valid while not granted SHALL keep its move stable until accepted.

Reset
REQ-028 On rst_in, the block SHALL:
  - set state = IDLE, board_reg = 0, last_grant = port 1 (so port 0 wins the first tie);
  - clear the counter;
  - drive all valid, done, busy and timeout outputs to 0.
REQ-029 Reset SHALL take precedence over every other event, including mid-operation in ISSUE, WAIT or DONE; the pending move SHALL be dropped without a done pulse.

Verification
REQ-030 Load with board B, then req0 move e2e4; executor returns B' 1 cycle after request -> exec_board_out = B at issue, req0_done_out pulse 4 cycles after acceptance, board_out = B', two board_valid_out pulses in total.
REQ-031 req0 and req1 valid together from reset -> req0 served first, then req1 (exec_board_out = req0 result), each with exactly one done pulse on its own port.
REQ-032 Load valid and req1 valid in the same IDLE cycle -> load accepted first, req1 accepted the following cycle.
REQ-033 TIMEOUT_CYCLES = 8, executor silent -> timeout_out pulses after 8 WAIT cycles, no done, board_out unchanged; a late exec_valid_in in IDLE is ignored.
REQ-034 rst_in asserted during WAIT, exec_valid_in arriving afterwards -> board_out = 0, no done pulse, busy_out = 0, state IDLE.
